// File: rtl/bus_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bus_timer : memory-mapped countdown timer (CTRL/PRESET/COUNT), IRQ to CPU  |
// | Optional: TIMER_PRESCALE_EN adds an 8-bit prescaler in CTRL[15:8]          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module bus_timer #(
   parameter int CNT_W = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  Addr,
   input  logic        WE,
   input  logic [31:0] DIN,
   output logic [31:0] DOUT,
   output logic        IRQ
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);
   localparam logic [1:0]       c_addr_ctrl   = 2'd0;
   localparam logic [1:0]       c_addr_preset = 2'd1;
   localparam logic [1:0]       c_addr_count  = 2'd2;

   state_t           state_q, state_d;
   logic [3:0]       ctrl_q, ctrl_d;
   logic [CNT_W-1:0] preset_q, preset_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             irq_flag_q, irq_flag_d;

   logic             w_ctrl_wr;
   logic             w_preset_wr;
   logic             w_tick;
   logic [7:0]       w_ps_rd;
   logic             w_irq_set;
   logic             w_irq_clr;
   logic             w_en_clr;
   logic             w_unused_din;

   assign w_ctrl_wr    = WE && (Addr == c_addr_ctrl);
   assign w_preset_wr  = WE && (Addr == c_addr_preset);
   assign w_unused_din = ^DIN;

`ifdef TIMER_PRESCALE_EN
   logic [7:0] ps_q, ps_d;
   logic [7:0] ps_cnt_q, ps_cnt_d;

   // >= rather than == so a PS lowered mid-count cannot strand the counter
   assign w_tick  = (ps_cnt_q >= ps_q);
   assign w_ps_rd = ps_q;

   always_comb begin
      ps_d     = w_ctrl_wr ? DIN[15:8] : ps_q;
      ps_cnt_d = ps_cnt_q;
      if (state_q == ST_LOAD) begin
         ps_cnt_d = 8'd0;
      end else if ((state_q == ST_CNT) && ctrl_q[0]) begin
         ps_cnt_d = w_tick ? 8'd0 : ps_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ps_q     <= 8'd0;
         ps_cnt_q <= 8'd0;
      end else begin
         ps_q     <= ps_d;
         ps_cnt_q <= ps_cnt_d;
      end
   end
`else
   assign w_tick  = 1'b1;
   assign w_ps_rd = 8'd0;
`endif

   always_comb begin
      state_d    = state_q;
      ctrl_d     = ctrl_q;
      preset_d   = preset_q;
      count_d    = count_q;
      irq_flag_d = irq_flag_q;
      w_irq_set  = 1'b0;
      w_irq_clr  = 1'b0;
      w_en_clr   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (ctrl_q[0]) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            count_d = preset_q;
            state_d = ST_CNT;
         end
         ST_CNT: begin
            if (!ctrl_q[0]) begin
               state_d = ST_IDLE;
            end else if (w_tick) begin
               if (count_q > c_cnt_one) begin
                  count_d = count_q - c_cnt_one;
               end else begin
                  count_d   = '0;
                  w_irq_set = 1'b1;
                  state_d   = ST_INT;
               end
            end
         end
         ST_INT: begin
            // MODE 1x falls into the one-shot branch
            if (ctrl_q[2:1] == 2'b01) begin
               w_irq_clr = 1'b1;
               state_d   = ST_LOAD;
            end else begin
               w_en_clr = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (w_en_clr)    ctrl_d[0] = 1'b0;
      if (w_ctrl_wr)   ctrl_d    = DIN[3:0];
      if (w_preset_wr) preset_d  = DIN[CNT_W-1:0];

      // a set on the same edge as a CTRL write must win so no interrupt is lost
      if (w_irq_clr || w_ctrl_wr) irq_flag_d = 1'b0;
      if (w_irq_set)              irq_flag_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         ctrl_q     <= 4'd0;
         preset_q   <= '0;
         count_q    <= '0;
         irq_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         preset_q   <= preset_d;
         count_q    <= count_d;
         irq_flag_q <= irq_flag_d;
      end
   end

   always_comb begin
      case (Addr)
         c_addr_ctrl:   DOUT = {16'd0, w_ps_rd, 4'd0, ctrl_q};
         c_addr_preset: DOUT = 32'(preset_q);
         c_addr_count:  DOUT = 32'(count_q);
         default:       DOUT = 32'd0;
      endcase
   end

   assign IRQ = ctrl_q[3] & irq_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_timer.sv
`default_nettype none
// tb_bus_timer : directed, self-checking bench for bus_timer with hand-computed expectations.
module tb_bus_timer;

   logic        clk;
   logic        reset;
   logic [1:0]  Addr;
   logic        WE;
   logic [31:0] DIN;
   logic [31:0] DOUT;
   logic        IRQ;

   int n_checks = 0;
   int n_errors = 0;

   bus_timer #(.CNT_W(32)) u_dut (
      .clk   (clk),
      .reset (reset),
      .Addr  (Addr),
      .WE    (WE),
      .DIN   (DIN),
      .DOUT  (DOUT),
      .IRQ   (IRQ)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // advance n rising edges, then settle 1ns past the edge
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // the write lands on the next rising edge; returns 1ns after it
   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      Addr = a;
      DIN  = d;
      WE   = 1'b1;
      @(posedge clk);
      #1;
      WE   = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
      Addr = a;
      #1;
      chk(tag, DOUT, exp);
   endtask

   initial begin
      reset = 1'b1;
      WE    = 1'b0;
      Addr  = 2'd0;
      DIN   = 32'd0;
      tick(3);
      reset = 1'b0;

      // reset state
      rd_chk("rst_ctrl",   2'd0, 32'd0);
      rd_chk("rst_preset", 2'd1, 32'd0);
      rd_chk("rst_count",  2'd2, 32'd0);
      rd_chk("rst_rsvd",   2'd3, 32'd0);
      chk("rst_irq", 32'(IRQ), 32'd0);

      // one-shot, PRESET=5: IRQ rises after write edge + 7 and holds
      bus_wr(2'd1, 32'd5);
      bus_wr(2'd0, 32'h9);
      tick(2);
      rd_chk("os_cnt_load", 2'd2, 32'd5);
      tick(4);
      chk("os_irq_t6", 32'(IRQ), 32'd0);
      rd_chk("os_cnt_t6", 2'd2, 32'd1);
      tick(1);
      chk("os_irq_t7", 32'(IRQ), 32'd1);
      rd_chk("os_cnt_t7", 2'd2, 32'd0);
      tick(1);
      rd_chk("os_ctrl_en_clr", 2'd0, 32'h8);
      tick(3);
      chk("os_irq_held", 32'(IRQ), 32'd1);
      bus_wr(2'd0, 32'h8);
      chk("os_irq_cleared", 32'(IRQ), 32'd0);

      // auto-reload, PRESET=3: one-cycle IRQ every 5 cycles
      bus_wr(2'd1, 32'd3);
      bus_wr(2'd0, 32'hB);
      for (int k = 1; k <= 20; k++) begin
         tick(1);
         chk($sformatf("ar_irq_%0d", k), 32'(IRQ), (k >= 5 && (k - 5) % 5 == 0) ? 32'd1 : 32'd0);
         if (k >= 2 && k <= 5) rd_chk($sformatf("ar_cnt_%0d", k), 2'd2, 32'(5 - k));
      end
      bus_wr(2'd0, 32'h0);
      tick(3);
      chk("ar_stop_irq", 32'(IRQ), 32'd0);

      // disable mid-count freezes COUNT; re-enable reloads the new PRESET
      bus_wr(2'd1, 32'd10);
      bus_wr(2'd0, 32'h9);
      tick(5);
      rd_chk("mid_cnt_7", 2'd2, 32'd7);
      bus_wr(2'd0, 32'h8);
      tick(10);
      rd_chk("mid_frozen", 2'd2, 32'd6);
      chk("mid_no_irq", 32'(IRQ), 32'd0);
      bus_wr(2'd1, 32'd2);
      bus_wr(2'd0, 32'h9);
      tick(2);
      rd_chk("mid_reload", 2'd2, 32'd2);
      tick(1);
      chk("mid_irq_t3", 32'(IRQ), 32'd0);
      tick(1);
      chk("mid_irq_t4", 32'(IRQ), 32'd1);
      bus_wr(2'd0, 32'h8);
      chk("mid_irq_clr", 32'(IRQ), 32'd0);

      // PRESET=0 behaves like PRESET=1
      bus_wr(2'd1, 32'd0);
      bus_wr(2'd0, 32'h9);
      tick(2);
      chk("p0_irq_t2", 32'(IRQ), 32'd0);
      tick(1);
      chk("p0_irq_t3", 32'(IRQ), 32'd1);
      bus_wr(2'd0, 32'h8);
      chk("p0_irq_clr", 32'(IRQ), 32'd0);

      // IM=0: flag sets silently; the later CTRL write that sets IM clears it
      bus_wr(2'd1, 32'd2);
      bus_wr(2'd0, 32'h1);
      tick(5);
      chk("im0_irq", 32'(IRQ), 32'd0);
      rd_chk("im0_ctrl", 2'd0, 32'h0);
      bus_wr(2'd0, 32'h8);
      chk("im0_then_im1", 32'(IRQ), 32'd0);
      tick(2);
      chk("im0_still_low", 32'(IRQ), 32'd0);

      // CTRL write on the flag-setting edge: set wins; on the INT edge: written EN wins
      bus_wr(2'd1, 32'd2);
      bus_wr(2'd0, 32'h9);
      tick(3);
      bus_wr(2'd0, 32'h9);
      chk("coll_set_wins", 32'(IRQ), 32'd1);
      bus_wr(2'd0, 32'h9);
      rd_chk("coll_en_kept", 2'd0, 32'h9);
      chk("coll_int_clr", 32'(IRQ), 32'd0);
      tick(3);
      chk("coll_rerun_t8", 32'(IRQ), 32'd0);
      tick(1);
      chk("coll_rerun_t9", 32'(IRQ), 32'd1);
      bus_wr(2'd0, 32'h8);

      // PRESET write during CNT only applies at the next LOAD
      bus_wr(2'd1, 32'd4);
      bus_wr(2'd0, 32'h9);
      tick(2);
      bus_wr(2'd1, 32'd7);
      rd_chk("pw_cnt", 2'd2, 32'd3);
      rd_chk("pw_preset", 2'd1, 32'd7);
      tick(2);
      chk("pw_irq_t5", 32'(IRQ), 32'd0);
      tick(1);
      chk("pw_irq_t6", 32'(IRQ), 32'd1);
      bus_wr(2'd0, 32'h8);

      // reset mid-count
      bus_wr(2'd1, 32'd9);
      bus_wr(2'd0, 32'hB);
      tick(4);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      rd_chk("mrst_ctrl",   2'd0, 32'd0);
      rd_chk("mrst_preset", 2'd1, 32'd0);
      rd_chk("mrst_count",  2'd2, 32'd0);
      chk("mrst_irq", 32'(IRQ), 32'd0);
      tick(3);
      rd_chk("mrst_idle", 2'd2, 32'd0);

      // CTRL unused bits, and the prescale field when present
      bus_wr(2'd0, 32'hFFFF_FF06);
`ifdef TIMER_PRESCALE_EN
      rd_chk("ctrl_mask", 2'd0, 32'h0000_FF06);
`else
      rd_chk("ctrl_mask", 2'd0, 32'h0000_0006);
`endif
      bus_wr(2'd0, 32'h0);

`ifdef TIMER_PRESCALE_EN
      // PS=2, PRESET=4, auto-reload: 14-cycle period
      bus_wr(2'd1, 32'd4);
      bus_wr(2'd0, 32'h020B);
      rd_chk("ps_ctrl", 2'd0, 32'h020B);
      for (int k = 1; k <= 30; k++) begin
         tick(1);
         chk($sformatf("ps_irq_%0d", k), 32'(IRQ), (k == 14 || k == 28) ? 32'd1 : 32'd0);
      end
      bus_wr(2'd0, 32'h0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
